// File: rtl/kpn_pkg.sv
// Shared KPN token types and channel defaults.
// Imported by the FIFO channel, split_module and other process blocks.
package kpn_pkg;

    localparam int TOKEN_W = 16;
    localparam int KPN_FIFO_DEPTH = 4;

    typedef logic [TOKEN_W-1:0] token_t;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'b00,
        OCC_DEC  = 2'b01,
        OCC_INC  = 2'b10,
        OCC_BOTH = 2'b11
    } occ_op_t;

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for a KPN channel: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int WIDTH  = TOKEN_W,
    parameter int DEPTH  = KPN_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-slot read and write on a full channel returns the old token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded KPN FIFO channel with Kahn blocking flags.
// Optional peak-occupancy tracking under KPN_FIFO_WATERMARK_EN.
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int WIDTH  = TOKEN_W,
    parameter int DEPTH  = KPN_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [WIDTH-1:0]  entry_1,
    output logic              full,
    input  logic              rd,
    output logic [WIDTH-1:0]  output_1,
    output logic              valid,
    output logic              empty,
    output logic [ADDR_W:0]   count
`ifdef KPN_FIFO_WATERMARK_EN
    ,
    output logic [ADDR_W:0]   high_water
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              rd_acc;
    logic              wr_acc;
    occ_op_t           occ_op;

    // A read frees a slot in the same cycle, so a full channel still accepts.
    assign rd_acc = rd && !empty;
    assign wr_acc = wr && (!full || rd_acc);
    assign occ_op = occ_op_t'({wr_acc, rd_acc});

    always_comb begin
        count_next = count;
        unique case (occ_op)
            OCC_INC:  count_next = count + 1'b1;
            OCC_DEC:  count_next = count - 1'b1;
            OCC_HOLD: count_next = count;
            OCC_BOTH: count_next = count;
            default:  count_next = count;
        endcase
    end

    kpn_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (entry_1),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (output_1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            valid <= rd_acc;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

`ifdef KPN_FIFO_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_water <= '0;
        end else if (count_next > high_water) begin
            high_water <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel (DEPTH=4).
// Covers ordering, blocking flags, full/empty corner cases and reset.
module tb_kpn_fifo_channel;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [15:0] entry_1;
    logic        full;
    logic        rd;
    logic [15:0] output_1;
    logic        valid;
    logic        empty;
    logic [2:0]  count;
`ifdef KPN_FIFO_WATERMARK_EN
    logic [2:0]  high_water;
`endif

    int errors = 0;
    int checks = 0;

    kpn_fifo_channel dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .entry_1  (entry_1),
        .full     (full),
        .rd       (rd),
        .output_1 (output_1),
        .valid    (valid),
        .empty    (empty),
        .count    (count)
`ifdef KPN_FIFO_WATERMARK_EN
        ,
        .high_water (high_water)
`endif
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        wr = w;
        entry_1 = d;
        rd = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        entry_1 = '0;
    endtask

    task automatic flags(input string tag, input int c, input logic e,
                         input logic f);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
    endtask

    task automatic rd_exp(input string tag, input logic [15:0] exp);
        cyc(1'b0, 16'd0, 1'b1);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".data"}, 32'(output_1), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        entry_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        flags("rst", 0, 1'b1, 1'b0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.data", 32'(output_1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b1, 16'd10, 1'b0);
        cyc(1'b1, 16'd50, 1'b0);
        cyc(1'b1, 16'd90, 1'b0);
        flags("w3", 3, 1'b0, 1'b0);
        rd_exp("r10", 16'd10);
        rd_exp("r50", 16'd50);
        rd_exp("r90", 16'd90);
        flags("drain3", 0, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 1'b0);
        chk("idle.valid", 32'(valid), 32'd0);
        chk("idle.hold", 32'(output_1), 32'd90);

        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            if (i == 3) flags("fill3", 3, 1'b0, 1'b0);
            if (i == 4) flags("fill4", 4, 1'b0, 1'b1);
        end
        flags("fill5", 4, 1'b0, 1'b1);
        rd_exp("d1", 16'd1);
        rd_exp("d2", 16'd2);
        rd_exp("d3", 16'd3);
        rd_exp("d4", 16'd4);
        flags("dfill", 0, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 1'b1);
        chk("rdempty.valid", 32'(valid), 32'd0);
        chk("rdempty.hold", 32'(output_1), 32'd4);

        for (int i = 11; i <= 14; i++) cyc(1'b1, 16'(i), 1'b0);
        flags("refill", 4, 1'b0, 1'b1);
        cyc(1'b1, 16'd7, 1'b1);
        chk("fullrw.valid", 32'(valid), 32'd1);
        chk("fullrw.data", 32'(output_1), 32'd11);
        flags("fullrw", 4, 1'b0, 1'b1);
        rd_exp("d12", 16'd12);
        rd_exp("d13", 16'd13);
        rd_exp("d14", 16'd14);
        rd_exp("d7", 16'd7);
        flags("dfull", 0, 1'b1, 1'b0);

        cyc(1'b1, 16'd42, 1'b1);
        chk("emptyrw.valid", 32'(valid), 32'd0);
        chk("emptyrw.hold", 32'(output_1), 32'd7);
        flags("emptyrw", 1, 1'b0, 1'b0);
        rd_exp("d42", 16'd42);
        flags("d42", 0, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'(100 + i), 1'b0);
            rd_exp($sformatf("wrap%0d", i), 16'(100 + i));
        end
        cyc(1'b1, 16'd200, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 16'(201 + i), 1'b1);
            chk($sformatf("strm%0d.data", i), 32'(output_1), 32'(200 + i));
            chk($sformatf("strm%0d.cnt", i), 32'(count), 32'd1);
        end
        rd_exp("strmlast", 16'd206);
        flags("strm", 0, 1'b1, 1'b0);

`ifdef KPN_FIFO_WATERMARK_EN
        chk("high_water", 32'(high_water), 32'd4);
`endif

        cyc(1'b1, 16'd33, 1'b0);
        cyc(1'b1, 16'd34, 1'b0);
        rd_exp("pre_rst", 16'd33);
        #50;
        rst_n = 1'b0;
        #1;
        flags("mid_rst", 0, 1'b1, 1'b0);
        chk("mid_rst.valid", 32'(valid), 32'd0);
        chk("mid_rst.data", 32'(output_1), 32'd0);
`ifdef KPN_FIFO_WATERMARK_EN
        chk("mid_rst.hw", 32'(high_water), 32'd0);
`endif
        #100;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 16'd0, 1'b1);
        chk("post_rst.valid", 32'(valid), 32'd0);
        flags("post_rst", 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
